// File: rtl/nn_layer_pkg.sv
// Shared types and defaults for the NN layer wrappers and the serializer.
// Provides the serializer state encoding and the index-width helper.
package nn_layer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

  localparam int NN_DEFAULT     = 30;
  localparam int DATA_W_DEFAULT = 16;

  // A one-word frame still needs a 1-bit index register.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_ser_capture.sv
// One lane of the serializer capture bank: data register, captured bit,
// and overflow detect for a repeat arrival on an already-captured lane.
module layer_ser_capture
  import nn_layer_pkg::*;
#(
  parameter int DW = DATA_W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  input  logic          clr_i,
  output logic          cap_o,
  output logic [DW-1:0] word_o,
  output logic          ovf_o
);

  logic          cap_q, cap_d;
  logic [DW-1:0] data_q, data_d;
  logic          store;

  assign store  = valid_i & ~cap_q;
  assign cap_o  = cap_q | valid_i;
  assign word_o = store ? data_i : data_q;
  assign ovf_o  = valid_i & cap_q;

  always_comb begin
    cap_d  = clr_i ? 1'b0 : cap_o;
    data_d = word_o;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cap_q  <= 1'b0;
      data_q <= '0;
    end else begin
      cap_q  <= cap_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/layer_serializer.sv
// Double-buffered parallel-to-serial bridge between two NN layers.
// Optional overflow reporting ports under `LAYER_SER_OVF_DET_EN.
module layer_serializer
  import nn_layer_pkg::*;
#(
  parameter int  NN        = NN_DEFAULT,
  parameter int  dataWidth = DATA_W_DEFAULT,
  localparam int IW        = idx_w(NN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NN-1:0]           lane_valid,
  input  logic [NN*dataWidth-1:0] lane_data,
  output logic [dataWidth-1:0]    x_out,
  output logic                    x_valid,
  output logic                    busy,
  output logic                    frame_done
`ifdef LAYER_SER_OVF_DET_EN
  ,
  output logic                    ovf_sticky,
  output logic [IW-1:0]           ovf_lane
`endif
);

  logic [NN-1:0]        cap;
  logic [NN-1:0]        ovf;
  logic [dataWidth-1:0] word    [NN];
  logic [dataWidth-1:0] shift_q [NN];
  logic                 load;
  logic                 complete;
  logic                 last;

  ser_state_e           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [dataWidth-1:0] x_out_q, x_out_d;
  logic                 x_valid_q, x_valid_d;
  logic                 busy_q, busy_d;
  logic                 fd_q, fd_d;

  for (genvar g = 0; g < NN; g++) begin : g_lane
    layer_ser_capture #(
      .DW(dataWidth)
    ) u_cap (
      .clk    (clk),
      .rst    (rst),
      .valid_i(lane_valid[g]),
      .data_i (lane_data[g*dataWidth +: dataWidth]),
      .clr_i  (load),
      .cap_o  (cap[g]),
      .word_o (word[g]),
      .ovf_o  (ovf[g])
    );
  end

  assign complete = &cap;
  assign last     = (idx_q == IW'(NN-1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    x_out_d   = x_out_q;
    x_valid_d = 1'b0;
    busy_d    = 1'b0;
    fd_d      = 1'b0;
    load      = 1'b0;
    if (state_q == SHIFT && !last) begin
      idx_d     = idx_q + 1'b1;
      x_out_d   = shift_q[idx_d];
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
      fd_d      = (idx_d == IW'(NN-1));
    end else if (complete) begin
      // Lane 0 goes straight to the output from the bank being copied.
      load      = 1'b1;
      state_d   = SHIFT;
      idx_d     = '0;
      x_out_d   = word[0];
      x_valid_d = 1'b1;
      busy_d    = 1'b1;
      fd_d      = (NN == 1);
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      x_out_q   <= '0;
      x_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      x_out_q   <= x_out_d;
      x_valid_q <= x_valid_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NN; i++) shift_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < NN; i++) shift_q[i] <= word[i];
    end
  end

  assign x_out      = x_out_q;
  assign x_valid    = x_valid_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;

`ifdef LAYER_SER_OVF_DET_EN
  logic          ovf_sticky_q, ovf_sticky_d;
  logic [IW-1:0] ovf_lane_q, ovf_lane_d;
  logic [IW-1:0] ovf_low;

  always_comb begin
    ovf_low = '0;
    for (int i = NN - 1; i >= 0; i--) begin
      if (ovf[i]) ovf_low = IW'(i);
    end
    ovf_sticky_d = ovf_sticky_q;
    ovf_lane_d   = ovf_lane_q;
    if (|ovf && !ovf_sticky_q) begin
      ovf_sticky_d = 1'b1;
      ovf_lane_d   = ovf_low;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky_q <= 1'b0;
      ovf_lane_q   <= '0;
    end else begin
      ovf_sticky_q <= ovf_sticky_d;
      ovf_lane_q   <= ovf_lane_d;
    end
  end

  assign ovf_sticky = ovf_sticky_q;
  assign ovf_lane   = ovf_lane_q;
`else
  logic unused_ovf;
  assign unused_ovf = |ovf;
`endif

endmodule

// File: tb/tb_layer_serializer.sv
// Scoreboard bench for layer_serializer (NN=30, 16-bit words).
// Stimulus pushes expected words with their cycle; a negedge monitor checks.
module tb_layer_serializer;

  localparam int NN = 30;
  localparam int DW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NN-1:0]    lane_valid = '0;
  logic [NN*DW-1:0] lane_data = '0;
  logic [DW-1:0]    x_out;
  logic             x_valid;
  logic             busy;
  logic             frame_done;
`ifdef LAYER_SER_OVF_DET_EN
  logic             ovf_sticky;
  logic [4:0]       ovf_lane;
`endif

  layer_serializer #(
    .NN       (NN),
    .dataWidth(DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lane_valid(lane_valid),
    .lane_data (lane_data),
    .x_out     (x_out),
    .x_valid   (x_valid),
    .busy      (busy),
    .frame_done(frame_done)
`ifdef LAYER_SER_OVF_DET_EN
    ,
    .ovf_sticky(ovf_sticky),
    .ovf_lane  (ovf_lane)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] d;
    logic        fd;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (x_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word cyc=%0d got %h fd=%b expected none",
                   cyc, x_out, frame_done);
        end else begin
          e = sb.pop_front();
          if (cyc != e.c || x_out !== e.d || frame_done !== e.fd) begin
            errors++;
            $display("FAIL word got cyc=%0d %h fd=%b expected cyc=%0d %h fd=%b",
                     cyc, x_out, frame_done, e.c, e.d, e.fd);
          end
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_idle cyc=%0d got %b expected 0", cyc, frame_done);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_lane(input int i, input logic [15:0] d);
    lane_valid[i] = 1'b1;
    lane_data[i*DW +: DW] = d;
  endtask

  task automatic push_frame(input int c0, input logic [15:0] base);
    for (int i = 0; i < NN; i++) sb.push_back('{c0 + i, base + 16'(i), i == NN - 1});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  int b;
  int r;

  initial begin
    // Reset with random lanes toggling
    lane_valid = 30'($urandom);
    lane_data  = {15{$urandom}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_x_out", 32'(x_out), 32'd0);
    chk("rst_x_valid", 32'(x_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
`ifdef LAYER_SER_OVF_DET_EN
    chk("rst_ovf_sticky", 32'(ovf_sticky), 32'd0);
`endif
    lane_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_x_valid", 32'(x_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);

    // All lanes at once
    b = cyc;
    wait_cyc(b + 10);
    for (int i = 0; i < NN; i++) set_lane(i, 16'h0100 + 16'(i));
    push_frame(b + 11, 16'h0100);
    wait_cyc(b + 11);
    lane_valid = '0;
    wait_cyc(b + 20);
    @(negedge clk);
    chk("t2_busy_mid", 32'(busy), 32'd1);
    wait_cyc(b + 41);
    @(negedge clk);
    chk("t2_busy_after", 32'(busy), 32'd0);
    chk("t2_valid_after", 32'(x_valid), 32'd0);
    drain("t2_drain");

    // Staggered arrival
    b = cyc;
    for (int i = 0; i < NN; i++) begin
      wait_cyc(b + 10 + i);
      lane_valid = '0;
      set_lane(i, 16'h0100 + 16'(i));
    end
    push_frame(b + 40, 16'h0100);
    wait_cyc(b + 40);
    lane_valid = '0;
    drain("t3_drain");

    // Back-to-back frames
    b = cyc;
    wait_cyc(b + 10);
    for (int i = 0; i < NN; i++) set_lane(i, 16'h0A00 + 16'(i));
    push_frame(b + 11, 16'h0A00);
    push_frame(b + 41, 16'h0B00);
    wait_cyc(b + 11);
    lane_valid = '0;
    wait_cyc(b + 25);
    for (int i = 0; i < NN; i++) set_lane(i, 16'h0B00 + 16'(i));
    wait_cyc(b + 26);
    lane_valid = '0;
    wait_cyc(b + 55);
    @(negedge clk);
    chk("t4_busy_gapless", 32'(busy), 32'd1);
    drain("t4_drain");
    chk("t4_idle_after", 32'(x_valid), 32'd0);

    // Overflow on lane 3
    b = cyc;
    wait_cyc(b + 5);
    set_lane(3, 16'h1111);
    wait_cyc(b + 6);
    set_lane(3, 16'h2222);
    wait_cyc(b + 7);
    lane_valid = '0;
    wait_cyc(b + 10);
    for (int i = 0; i < NN; i++) begin
      if (i != 3) set_lane(i, 16'h0500 + 16'(i));
    end
    for (int i = 0; i < NN; i++)
      sb.push_back('{b + 11 + i, (i == 3) ? 16'h1111 : 16'h0500 + 16'(i), i == NN - 1});
    wait_cyc(b + 11);
    lane_valid = '0;
    drain("t5_drain");
`ifdef LAYER_SER_OVF_DET_EN
    chk("t5_ovf_sticky", 32'(ovf_sticky), 32'd1);
    chk("t5_ovf_lane", 32'(ovf_lane), 32'd3);
`endif

    // Reset mid-shift, with a partial next frame pending
    b = cyc;
    wait_cyc(b + 10);
    for (int i = 0; i < NN; i++) set_lane(i, 16'h0600 + 16'(i));
    for (int i = 0; i <= 12; i++) sb.push_back('{b + 11 + i, 16'h0600 + 16'(i), 1'b0});
    wait_cyc(b + 11);
    lane_valid = '0;
    wait_cyc(b + 15);
    for (int i = 0; i < 5; i++) set_lane(i, 16'hDEAD);
    wait_cyc(b + 16);
    lane_valid = '0;
    wait_cyc(b + 23);
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_x_valid", 32'(x_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_sb_at_rst", 32'(sb.size()), 32'd0);
`ifdef LAYER_SER_OVF_DET_EN
    chk("t6_rst_ovf", 32'(ovf_sticky), 32'd0);
`endif
    wait_cyc(b + 25);
    rst = 1'b1;
    r = cyc;
    wait_cyc(r + 3);
    for (int i = 5; i < NN; i++) set_lane(i, 16'h0700 + 16'(i));
    wait_cyc(r + 4);
    lane_valid = '0;
    wait_cyc(r + 5);
    @(negedge clk);
    chk("t6_partial_idle", 32'(x_valid), 32'd0);
    wait_cyc(r + 6);
    for (int i = 0; i < 5; i++) set_lane(i, 16'h0700 + 16'(i));
    push_frame(r + 7, 16'h0700);
    wait_cyc(r + 7);
    lane_valid = '0;
    drain("t6_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
